// File: rtl/substitui_bytes_seq.sv
// Iterative AES SubBytes: substitutes BYTES_POR_CICLO bytes of a 128-bit state per clock, MSB chunk first.
// Optional feature macro INV_SBOX_EN adds the inverso port and the InvSubBytes tables.
module substitui_bytes_seq #(
   parameter int BYTES_POR_CICLO = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         entrada_valida,
   output logic         entrada_pronta,
   input  logic [127:0] bloco,
`ifdef INV_SBOX_EN
   input  logic         inverso,
`endif
   output logic         saida_valida,
   input  logic         saida_pronta,
   output logic [127:0] saida,
   output logic         ocupado
);

   localparam int N_CICLOS = 16 / BYTES_POR_CICLO;
   localparam int CW       = (N_CICLOS > 1) ? $clog2(N_CICLOS) : 1;

   localparam logic [1:0] OCIOSO    = 2'd0;
   localparam logic [1:0] PROCESSA  = 2'd1;
   localparam logic [1:0] CONCLUIDO = 2'd2;

   // Entry x lives at bits [2047-8x -: 8], so the first table row sits in the MSBs.
   localparam logic [2047:0] SBOX_DIR = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_dir(input logic [7:0] x);
      return SBOX_DIR[{~x, 3'b000} +: 8];
   endfunction

`ifdef INV_SBOX_EN
   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      return SBOX_INV[{~x, 3'b000} +: 8];
   endfunction

   logic inverso_q, inverso_d;
`endif

   logic [1:0]    estado_q, estado_d;
   logic [CW-1:0] contador_q, contador_d;
   logic [127:0]  trabalho_q, trabalho_d;
   logic [3:0]    byte_idx;
   logic [7:0]    byte_sub;

   // The loop unrolls into BYTES_POR_CICLO S-box copies, each fed by a byte picked from the current chunk.
   always_comb begin
      estado_d   = estado_q;
      contador_d = contador_q;
      trabalho_d = trabalho_q;
      byte_idx   = 4'd0;
      byte_sub   = 8'd0;
`ifdef INV_SBOX_EN
      inverso_d  = inverso_q;
`endif
      case (estado_q)
         OCIOSO: begin
            if (entrada_valida) begin
               trabalho_d = bloco;
               contador_d = '0;
               estado_d   = PROCESSA;
`ifdef INV_SBOX_EN
               inverso_d  = inverso;
`endif
            end
         end
         PROCESSA: begin
            for (int j = 0; j < BYTES_POR_CICLO; j++) begin
               byte_idx = 4'd15 - 4'(int'(contador_q) * BYTES_POR_CICLO + j);
`ifdef INV_SBOX_EN
               byte_sub = inverso_q ? sbox_inv(trabalho_q[{byte_idx, 3'b000} +: 8])
                                    : sbox_dir(trabalho_q[{byte_idx, 3'b000} +: 8]);
`else
               byte_sub = sbox_dir(trabalho_q[{byte_idx, 3'b000} +: 8]);
`endif
               trabalho_d[{byte_idx, 3'b000} +: 8] = byte_sub;
            end
            if (contador_q == CW'(N_CICLOS - 1)) begin
               contador_d = '0;
               estado_d   = CONCLUIDO;
            end else begin
               contador_d = contador_q + 1'b1;
            end
         end
         CONCLUIDO: begin
            if (saida_pronta) begin
               estado_d = OCIOSO;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q   <= OCIOSO;
         contador_q <= '0;
         trabalho_q <= '0;
`ifdef INV_SBOX_EN
         inverso_q  <= 1'b0;
`endif
      end else begin
         estado_q   <= estado_d;
         contador_q <= contador_d;
         trabalho_q <= trabalho_d;
`ifdef INV_SBOX_EN
         inverso_q  <= inverso_d;
`endif
      end
   end

   assign entrada_pronta = (estado_q == OCIOSO);
   assign ocupado        = (estado_q != OCIOSO);
   assign saida_valida   = (estado_q == CONCLUIDO);
   assign saida          = trabalho_q;

endmodule

// File: tb/tb_substitui_bytes_seq.sv
// Directed bench for substitui_bytes_seq (B=4): table of S-box vectors plus hold and mid-operation reset sequences.
module tb_substitui_bytes_seq;

   logic         clk;
   logic         rst_n;
   logic         entrada_valida;
   logic         entrada_pronta;
   logic [127:0] bloco;
   logic         inverso;
   logic         saida_valida;
   logic         saida_pronta;
   logic [127:0] saida;
   logic         ocupado;

   int comparados = 0;
   int mismatched = 0;

   typedef struct {
      logic [127:0] bloco;
      logic         inv;
      logic [127:0] esperado;
   } vetor_t;

   vetor_t tabela[$];

   substitui_bytes_seq #(.BYTES_POR_CICLO(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .entrada_valida (entrada_valida),
      .entrada_pronta (entrada_pronta),
      .bloco          (bloco),
`ifdef INV_SBOX_EN
      .inverso        (inverso),
`endif
      .saida_valida   (saida_valida),
      .saida_pronta   (saida_pronta),
      .saida          (saida),
      .ocupado        (ocupado)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string nome, input logic [127:0] atual, input logic [127:0] esperado);
      comparados++;
      if (atual !== esperado) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", nome, atual, esperado);
      end
   endtask

   // Waits (bounded) for entrada_pronta, presents one block for a single accept edge, then scrambles bloco.
   task automatic applyStimulus(input logic [127:0] b, input logic inv);
      int espera = 0;
      while (!entrada_pronta && espera < 50) begin
         @(posedge clk); #1;
         espera++;
      end
      if (espera == 50) checkOutput("entrada_pronta_timeout", 128'(entrada_pronta), 128'd1);
      entrada_valida = 1'b1;
      bloco          = b;
      inverso        = inv;
      @(posedge clk); #1;
      entrada_valida = 1'b0;
      bloco          = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      inverso        = ~inv;
   endtask

   task automatic runVector(input string nome, input logic [127:0] b, input logic inv,
                            input logic [127:0] esperado);
      int   ciclos = 0;
      logic ocupado_ok = 1'b1;
      applyStimulus(b, inv);
      while (!saida_valida && ciclos < 20) begin
         if (!ocupado) ocupado_ok = 1'b0;
         @(posedge clk); #1;
         ciclos++;
      end
      checkOutput({nome, "_latencia"}, 128'(ciclos), 128'd4);
      checkOutput({nome, "_ocupado"}, 128'(ocupado_ok), 128'd1);
      checkOutput({nome, "_saida"}, saida, esperado);
      saida_pronta = 1'b1;
      @(posedge clk); #1;
      saida_pronta = 1'b0;
      checkOutput({nome, "_pronta_apos"}, 128'(entrada_pronta), 128'd1);
   endtask

   initial begin
      int espera;

      tabela.push_back('{128'h0, 1'b0, {16{8'h63}}});
      tabela.push_back('{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230});
      tabela.push_back('{128'h0053ff0053ff0053ff0053ff0053ff00, 1'b0, 128'h63ed1663ed1663ed1663ed1663ed1663});
      tabela.push_back('{128'hff000000000000000000000000000053, 1'b0, 128'h166363636363636363636363636363ed});
      tabela.push_back('{{16{8'hff}}, 1'b0, {16{8'h16}}});
      tabela.push_back('{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h637c777bf26b6fc53001672bfed7ab76});
`ifdef INV_SBOX_EN
      tabela.push_back('{{16{8'h63}}, 1'b1, 128'h0});
      tabela.push_back('{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808});
`endif

      rst_n          = 1'b0;
      entrada_valida = 1'b0;
      bloco          = '0;
      inverso        = 1'b0;
      saida_pronta   = 1'b0;
      @(posedge clk); #1;
      checkOutput("reset_entrada_pronta", 128'(entrada_pronta), 128'd1);
      checkOutput("reset_ocupado", 128'(ocupado), 128'd0);
      checkOutput("reset_saida_valida", 128'(saida_valida), 128'd0);
      checkOutput("reset_saida", saida, 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (tabela[i]) begin
         runVector($sformatf("vec%0d", i), tabela[i].bloco, tabela[i].inv, tabela[i].esperado);
      end

      // Consumer stalls for 10 clocks while a new producer keeps pushing.
      applyStimulus(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0);
      espera = 0;
      while (!saida_valida && espera < 20) begin
         @(posedge clk); #1;
         espera++;
      end
      checkOutput("hold_chega_valida", 128'(saida_valida), 128'd1);
      entrada_valida = 1'b1;
      bloco          = 128'h0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("hold%0d_saida", c), saida, 128'hd42711aee0bf98f1b8b45de51e415230);
         checkOutput($sformatf("hold%0d_valida", c), 128'(saida_valida), 128'd1);
         checkOutput($sformatf("hold%0d_pronta", c), 128'(entrada_pronta), 128'd0);
      end
      entrada_valida = 1'b0;
      saida_pronta   = 1'b1;
      @(posedge clk); #1;
      saida_pronta = 1'b0;
      checkOutput("hold_volta_ocioso", 128'(entrada_pronta), 128'd1);
      checkOutput("hold_valida_cai", 128'(saida_valida), 128'd0);

      // Partial progress is visible chunk by chunk, saida_pronta is ignored, then an async reset discards it.
      applyStimulus(128'h0, 1'b0);
      saida_pronta = 1'b1;
      @(posedge clk); #1;
      checkOutput("parcial1_saida", saida, {{4{8'h63}}, 96'h0});
      @(posedge clk); #1;
      checkOutput("parcial2_saida", saida, {{8{8'h63}}, 64'h0});
      checkOutput("parcial2_ocupado", 128'(ocupado), 128'd1);
      checkOutput("parcial2_valida", 128'(saida_valida), 128'd0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_meio_saida", saida, 128'h0);
      checkOutput("rst_meio_valida", 128'(saida_valida), 128'd0);
      checkOutput("rst_meio_pronta", 128'(entrada_pronta), 128'd1);
      checkOutput("rst_meio_ocupado", 128'(ocupado), 128'd0);
      saida_pronta = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      runVector("pos_reset", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                128'hd42711aee0bf98f1b8b45de51e415230);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, mismatched);
      $finish;
   end

endmodule
